// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding,
// ACK byte values and the default frame sync marker.
package loader_pkg;

    // Frame-decoding states; ACK states are only reachable with LOADER_ACK_EN
    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ORG_HI   = 4'd1,
        ST_ORG_LO   = 4'd2,
        ST_CNT_HI   = 4'd3,
        ST_CNT_LO   = 4'd4,
        ST_DAT_HI   = 4'd5,
        ST_DAT_LO   = 4'd6,
        ST_CHK      = 4'd7,
        ST_ACK      = 4'd8,
        ST_ACK_WAIT = 4'd9
    } state_t;

    localparam logic [7:0] ACK_OK       = 8'h4B;  // 'K'
    localparam logic [7:0] ACK_ERR      = 8'h45;  // 'E'
    localparam logic [7:0] DEFAULT_SYNC = 8'h4C;  // 'L'

    // Running modulo-256 byte checksum
    function automatic logic [7:0] csum_add(input logic [7:0] i_sum, input logic [7:0] i_byte);
        return i_sum + i_byte;
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog for the program loader. Reloads on every received
// byte (or while disabled) and counts down otherwise; o_expire pulses for
// one cycle on the clock that completes LOAD_VALUE idle clocks.
module loader_timeout #(
    parameter logic [23:0] LOAD_VALUE = 24'd10_000_000
) (
    input  logic i_Clk,
    input  logic reset_,
    input  logic i_en,
    input  logic i_clear,
    output logic o_expire
);

    logic [23:0] r_cnt;

    // Down-counter: reload on byte or when idle, stop at zero
    always_ff @(posedge i_Clk) begin
        if (!reset_) begin
            r_cnt <= LOAD_VALUE;
        end else if (!i_en || i_clear) begin
            r_cnt <= LOAD_VALUE;
        end else if (r_cnt != 24'd0) begin
            r_cnt <= r_cnt - 24'd1;
        end
    end

    // The edge that takes the count from 1 to 0 is the last allowed idle clock
    assign o_expire = i_en && !i_clear && (r_cnt == 24'd1);

endmodule

// File: rtl/program_loader.sv
// Board-side UART program loader for the LC-3. Decodes
//   SYNC ORG_HI ORG_LO CNT_HI CNT_LO {DAT_HI DAT_LO}*CNT CHK
// writes the words to memory, holds the CPU in reset while loading and
// releases it only after a frame passes its 8-bit checksum.
// Optional feature macro: LOADER_ACK_EN adds a 'K'/'E' ACK byte to uart_tx.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic        i_Clk,
    input  logic        reset_,
    input  logic        i_rx_dv,
    input  logic [7:0]  i_rx_byte,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_data,
    output logic        o_mem_we,
    output logic        o_cpu_reset_,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [15:0] o_words
`ifdef LOADER_ACK_EN
    ,
    output logic        o_tx_dv,
    output logic [7:0]  o_tx_byte,
    input  logic        i_tx_done
`endif
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic [15:0] r_org;
    logic [15:0] r_cnt;
    logic [15:0] r_idx;
    logic [7:0]  r_dat_hi;
    logic [7:0]  r_sum;
    logic [15:0] r_mem_addr;
    logic [15:0] r_mem_data;
    logic        r_mem_we;
    logic        r_cpu_reset_;
    logic        r_done;
    logic        r_error;
    logic [15:0] r_words;

    logic        w_expire;
    logic        w_busy;
    logic        w_sync;
    logic [15:0] w_idx_nxt;
    logic [15:0] w_cnt_full;
    logic [7:0]  w_sum_nxt;

    assign w_sync     = i_rx_dv && (i_rx_byte == SYNC_BYTE);
    assign w_idx_nxt  = r_idx + 16'd1;
    assign w_cnt_full = {r_cnt[15:8], i_rx_byte};
    assign w_sum_nxt  = csum_add(r_sum, i_rx_byte);

    loader_timeout #(
        .LOAD_VALUE (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_Clk    (i_Clk),
        .reset_   (reset_),
        .i_en     (w_busy),
        .i_clear  (i_rx_dv),
        .o_expire (w_expire)
    );

    // State register
    always_ff @(posedge i_Clk) begin
        if (!reset_) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: byte-driven advance, watchdog forces a return to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (w_expire) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_sync)  w_state_nxt = ST_ORG_HI;
                ST_ORG_HI: if (i_rx_dv) w_state_nxt = ST_ORG_LO;
                ST_ORG_LO: if (i_rx_dv) w_state_nxt = ST_CNT_HI;
                ST_CNT_HI: if (i_rx_dv) w_state_nxt = ST_CNT_LO;
                ST_CNT_LO: if (i_rx_dv) w_state_nxt = (w_cnt_full == 16'd0) ? ST_CHK : ST_DAT_HI;
                ST_DAT_HI: if (i_rx_dv) w_state_nxt = ST_DAT_LO;
                ST_DAT_LO: if (i_rx_dv) w_state_nxt = (w_idx_nxt == r_cnt) ? ST_CHK : ST_DAT_HI;
`ifdef LOADER_ACK_EN
                ST_CHK:      if (i_rx_dv)   w_state_nxt = ST_ACK;
                ST_ACK:                     w_state_nxt = ST_ACK_WAIT;
                ST_ACK_WAIT: if (i_tx_done) w_state_nxt = ST_IDLE;
`else
                ST_CHK:      if (i_rx_dv)   w_state_nxt = ST_IDLE;
`endif
                default:                    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        w_busy = (r_state != ST_IDLE);
    end

    // Frame datapath: field capture, checksum, memory write and status flags
    always_ff @(posedge i_Clk) begin
        if (!reset_) begin
            r_org        <= 16'd0;
            r_cnt        <= 16'd0;
            r_idx        <= 16'd0;
            r_dat_hi     <= 8'd0;
            r_sum        <= 8'd0;
            r_mem_addr   <= 16'd0;
            r_mem_data   <= 16'd0;
            r_mem_we     <= 1'b0;
            r_cpu_reset_ <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_words      <= 16'd0;
        end else begin
            r_mem_we <= 1'b0;
            r_done   <= 1'b0;
            // CPU stays held after a timeout; only a good frame releases it
            if (w_expire) begin
                r_error <= 1'b1;
            end else if (i_rx_dv) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_sync) begin
                            r_cpu_reset_ <= 1'b0;
                            r_error      <= 1'b0;
                            r_sum        <= 8'd0;
                            r_idx        <= 16'd0;
                            r_words      <= 16'd0;
                        end
                    end
                    ST_ORG_HI: begin
                        r_org[15:8] <= i_rx_byte;
                        r_sum       <= w_sum_nxt;
                    end
                    ST_ORG_LO: begin
                        r_org[7:0] <= i_rx_byte;
                        r_sum      <= w_sum_nxt;
                    end
                    ST_CNT_HI: begin
                        r_cnt[15:8] <= i_rx_byte;
                        r_sum       <= w_sum_nxt;
                    end
                    ST_CNT_LO: begin
                        r_cnt[7:0] <= i_rx_byte;
                        r_sum      <= w_sum_nxt;
                    end
                    ST_DAT_HI: begin
                        r_dat_hi <= i_rx_byte;
                        r_sum    <= w_sum_nxt;
                    end
                    ST_DAT_LO: begin
                        // 16-bit add wraps xFFFF to x0000 naturally
                        r_mem_addr <= r_org + r_idx;
                        r_mem_data <= {r_dat_hi, i_rx_byte};
                        r_mem_we   <= 1'b1;
                        r_idx      <= w_idx_nxt;
                        r_words    <= r_words + 16'd1;
                        r_sum      <= w_sum_nxt;
                    end
                    ST_CHK: begin
                        if (i_rx_byte == r_sum) begin
                            r_done       <= 1'b1;
                            r_cpu_reset_ <= 1'b1;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef LOADER_ACK_EN
    logic [7:0] r_tx_byte;

    // ACK byte latched on the checksum byte; strobe comes from the ACK state
    always_ff @(posedge i_Clk) begin
        if (!reset_) begin
            r_tx_byte <= 8'd0;
        end else if (i_rx_dv && r_state == ST_CHK && !w_expire) begin
            r_tx_byte <= (i_rx_byte == r_sum) ? ACK_OK : ACK_ERR;
        end
    end

    assign o_tx_dv   = (r_state == ST_ACK);
    assign o_tx_byte = r_tx_byte;
`endif

    assign o_mem_addr   = r_mem_addr;
    assign o_mem_data   = r_mem_data;
    assign o_mem_we     = r_mem_we;
    assign o_cpu_reset_ = r_cpu_reset_;
    assign o_busy       = w_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_words      = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader (small timeout value).
module tb_program_loader;

    localparam logic [23:0] TMO = 24'd40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [15:0] mem_addr, mem_data, words;
    logic        mem_we, cpu_rst_n, busy, done, error;
`ifdef LOADER_ACK_EN
    logic        tx_dv;
    logic [7:0]  tx_byte;
    logic        tx_done = 1'b0;
    logic [7:0]  ack_q[$];
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] wa_q[$];
    logic [15:0] wd_q[$];
    int          done_cnt = 0;
    logic [7:0]  fr[$];

    program_loader #(.SYNC_BYTE(8'h4C), .TIMEOUT_CYCLES(TMO)) dut (
        .i_Clk        (clk),
        .reset_       (rst_n),
        .i_rx_dv      (rx_dv),
        .i_rx_byte    (rx_byte),
        .o_mem_addr   (mem_addr),
        .o_mem_data   (mem_data),
        .o_mem_we     (mem_we),
        .o_cpu_reset_ (cpu_rst_n),
        .o_busy       (busy),
        .o_done       (done),
        .o_error      (error),
        .o_words      (words)
`ifdef LOADER_ACK_EN
        ,
        .o_tx_dv      (tx_dv),
        .o_tx_byte    (tx_byte),
        .i_tx_done    (tx_done)
`endif
    );

    initial forever #5 clk = ~clk;

    // Log writes and done pulses away from the active edge
    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_data);
        end
        if (done) done_cnt++;
    end

`ifdef LOADER_ACK_EN
    // Model uart_tx: record the ACK byte, answer with a done pulse
    initial forever begin
        @(negedge clk);
        if (tx_dv) begin
            ack_q.push_back(tx_byte);
            repeat (3) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk);
            #1 tx_done = 1'b0;
        end
    end
`endif

    task clear_log();
        wa_q.delete();
        wd_q.delete();
        done_cnt = 0;
    endtask

    // Bytes of fr on consecutive cycles
    task send_frame();
        @(posedge clk); #1;
        foreach (fr[i]) begin
            rx_dv = 1'b1;
            rx_byte = fr[i];
            @(posedge clk); #1;
        end
        rx_dv = 1'b0;
    endtask

    task wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_checks++; n_errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, k);
        end
    endtask

    task test_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (cpu_rst_n !== 1'b1) begin n_errors++; $display("FAIL rst_cpu: got %b need 1", cpu_rst_n); end
        n_checks++; if (mem_we !== 1'b0)    begin n_errors++; $display("FAIL rst_we: got %b need 0", mem_we); end
        n_checks++; if (done !== 1'b0)      begin n_errors++; $display("FAIL rst_done: got %b need 0", done); end
        n_checks++; if (error !== 1'b0)     begin n_errors++; $display("FAIL rst_error: got %b need 0", error); end
        n_checks++; if (busy !== 1'b0)      begin n_errors++; $display("FAIL rst_busy: got %b need 0", busy); end
        n_checks++; if ({mem_addr, mem_data, words} !== 48'd0) begin n_errors++; $display("FAIL rst_regs: got %h %h %h need 0", mem_addr, mem_data, words); end
    endtask

    task test_normal();
        wait_idle(); clear_log();
        fr = {8'h4C};
        send_frame();
        @(negedge clk);
        n_checks++; if (busy !== 1'b1)      begin n_errors++; $display("FAIL norm_busy: got %b need 1", busy); end
        n_checks++; if (cpu_rst_n !== 1'b0) begin n_errors++; $display("FAIL norm_hold: got %b need 0", cpu_rst_n); end
        fr = {8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hF0};
        send_frame();
        @(negedge clk);
        n_checks++; if (done !== 1'b1)      begin n_errors++; $display("FAIL norm_done_time: got %b need 1", done); end
        n_checks++; if (cpu_rst_n !== 1'b1) begin n_errors++; $display("FAIL norm_release: got %b need 1", cpu_rst_n); end
        repeat (3) @(negedge clk);
        n_checks++; if (wa_q.size() !== 2)  begin n_errors++; $display("FAIL norm_nwr: got %0d need 2", wa_q.size()); end
        else begin
            n_checks++; if (wa_q[0] !== 16'h3000 || wd_q[0] !== 16'h1234) begin n_errors++; $display("FAIL norm_wr0: got %h=%h need 3000=1234", wa_q[0], wd_q[0]); end
            n_checks++; if (wa_q[1] !== 16'h3001 || wd_q[1] !== 16'hABCD) begin n_errors++; $display("FAIL norm_wr1: got %h=%h need 3001=abcd", wa_q[1], wd_q[1]); end
        end
        n_checks++; if (done_cnt !== 1)     begin n_errors++; $display("FAIL norm_done_cnt: got %0d need 1", done_cnt); end
        n_checks++; if (words !== 16'd2)    begin n_errors++; $display("FAIL norm_words: got %0d need 2", words); end
        n_checks++; if (error !== 1'b0)     begin n_errors++; $display("FAIL norm_error: got %b need 0", error); end
`ifdef LOADER_ACK_EN
        wait_idle();
        n_checks++; if (ack_q.size() == 0 || ack_q[ack_q.size()-1] !== 8'h4B) begin n_errors++; $display("FAIL norm_ack: got %0d bytes, need last 4b", ack_q.size()); end
`endif
    endtask

    task test_wrap();
        wait_idle(); clear_log();
        fr = {8'h4C, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h03};
        send_frame();
        repeat (3) @(negedge clk);
        n_checks++; if (wa_q.size() !== 2) begin n_errors++; $display("FAIL wrap_nwr: got %0d need 2", wa_q.size()); end
        else begin
            n_checks++; if (wa_q[0] !== 16'hFFFF || wd_q[0] !== 16'h0001) begin n_errors++; $display("FAIL wrap_wr0: got %h=%h need ffff=0001", wa_q[0], wd_q[0]); end
            n_checks++; if (wa_q[1] !== 16'h0000 || wd_q[1] !== 16'h0002) begin n_errors++; $display("FAIL wrap_wr1: got %h=%h need 0000=0002", wa_q[1], wd_q[1]); end
        end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL wrap_done: got %0d need 1", done_cnt); end
    endtask

    task test_sync_as_data();
        wait_idle(); clear_log();
        fr = {8'h4C, 8'h30, 8'h00, 8'h00, 8'h01, 8'h4C, 8'h4C, 8'hC9};
        send_frame();
        repeat (3) @(negedge clk);
        n_checks++; if (wa_q.size() !== 1 || wd_q[0] !== 16'h4C4C) begin n_errors++; $display("FAIL sync_data: got %0d writes, data %h need 1 of 4c4c", wa_q.size(), wd_q[0]); end
        n_checks++; if (done_cnt !== 1) begin n_errors++; $display("FAIL sync_done: got %0d need 1", done_cnt); end
    endtask

    task test_bad_chk();
        wait_idle(); clear_log();
        fr = {8'h4C, 8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hF1};
        send_frame();
        @(negedge clk);
        n_checks++; if (error !== 1'b1)     begin n_errors++; $display("FAIL bad_err_time: got %b need 1", error); end
        repeat (3) @(negedge clk);
        n_checks++; if (wa_q.size() !== 2)  begin n_errors++; $display("FAIL bad_nwr: got %0d need 2", wa_q.size()); end
        n_checks++; if (cpu_rst_n !== 1'b0) begin n_errors++; $display("FAIL bad_hold: got %b need 0", cpu_rst_n); end
        n_checks++; if (done_cnt !== 0)     begin n_errors++; $display("FAIL bad_done: got %0d need 0", done_cnt); end
`ifdef LOADER_ACK_EN
        wait_idle();
        n_checks++; if (ack_q.size() == 0 || ack_q[ack_q.size()-1] !== 8'h45) begin n_errors++; $display("FAIL bad_ack: got %0d bytes, need last 45", ack_q.size()); end
`endif
    endtask

    task test_noise_zero();
        wait_idle(); clear_log();
        fr = {8'h00, 8'hFF};
        send_frame();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0)  begin n_errors++; $display("FAIL noise_busy: got %b need 0", busy); end
        n_checks++; if (error !== 1'b1) begin n_errors++; $display("FAIL noise_keep_err: got %b need 1", error); end
        fr = {8'h4C};
        send_frame();
        @(negedge clk);
        n_checks++; if (error !== 1'b0) begin n_errors++; $display("FAIL zero_err_clr: got %b need 0", error); end
        fr = {8'h40, 8'h00, 8'h00, 8'h00, 8'h40};
        send_frame();
        repeat (3) @(negedge clk);
        n_checks++; if (wa_q.size() !== 0)  begin n_errors++; $display("FAIL zero_nwr: got %0d need 0", wa_q.size()); end
        n_checks++; if (done_cnt !== 1)     begin n_errors++; $display("FAIL zero_done: got %0d need 1", done_cnt); end
        n_checks++; if (cpu_rst_n !== 1'b1) begin n_errors++; $display("FAIL zero_release: got %b need 1", cpu_rst_n); end
        n_checks++; if (words !== 16'd0)    begin n_errors++; $display("FAIL zero_words: got %0d need 0", words); end
    endtask

    task test_timeout();
        wait_idle(); clear_log();
        fr = {8'h4C, 8'h30, 8'h00};
        send_frame();
        repeat (int'(TMO) - 5) @(negedge clk);
        n_checks++; if (busy !== 1'b1 || error !== 1'b0) begin n_errors++; $display("FAIL tmo_early: busy=%b error=%b need 1 0", busy, error); end
        repeat (10) @(negedge clk);
        n_checks++; if (error !== 1'b1)     begin n_errors++; $display("FAIL tmo_error: got %b need 1", error); end
        n_checks++; if (busy !== 1'b0)      begin n_errors++; $display("FAIL tmo_busy: got %b need 0", busy); end
        n_checks++; if (cpu_rst_n !== 1'b0) begin n_errors++; $display("FAIL tmo_hold: got %b need 0", cpu_rst_n); end
    endtask

    task test_reset_mid();
        wait_idle(); clear_log();
        fr = {8'h4C, 8'h30, 8'h00, 8'h00, 8'h02, 8'h12};
        send_frame();
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (wa_q.size() !== 0)  begin n_errors++; $display("FAIL rmid_nwr: got %0d need 0", wa_q.size()); end
        n_checks++; if (busy !== 1'b0 || error !== 1'b0 || cpu_rst_n !== 1'b1) begin n_errors++; $display("FAIL rmid_flags: busy=%b err=%b cpu=%b need 0 0 1", busy, error, cpu_rst_n); end
        n_checks++; if ({mem_addr, mem_data, words} !== 48'd0) begin n_errors++; $display("FAIL rmid_regs: got %h %h %h need 0", mem_addr, mem_data, words); end
        fr = {8'h4C, 8'h30, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hF0};
        send_frame();
        repeat (3) @(negedge clk);
        n_checks++; if (wa_q.size() !== 2 || done_cnt !== 1) begin n_errors++; $display("FAIL rmid_reload: got %0d writes %0d done need 2 1", wa_q.size(), done_cnt); end
        n_checks++; if (cpu_rst_n !== 1'b1) begin n_errors++; $display("FAIL rmid_release: got %b need 1", cpu_rst_n); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_wrap();
        test_sync_as_data();
        test_bad_chk();
        test_noise_zero();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
